dfi_init_ctrl: RTL
==================

Name: dfi_init_ctrl

Overview:
- Controller-side initiator for the DFI initialization handshake and memory power-up sequencing; it is the counterpart of the PHY side that receives dfi_init_start and returns dfi_init_done.
- Sequences dfi_reset_n and dfi_cke across all DFI phases, then requests PHY init/training and waits for completion, with a timeout.
- Sits between software/top-level control (start pulse, status) and the DFI phase inputs of the PHY.

Parameters:
- NPHASES, 8, number of DFI phases; the reset_n and cke outputs are replicated per phase.
- RESET_CYCLES, 16, cycles dfi_reset_n is held low after start; range 1..2^CNT_W-1.
- CKE_DELAY_CYCLES, 8, cycles between reset_n release and CKE assertion; range 1..2^CNT_W-1.
- INIT_TIMEOUT, 1024, maximum cycles from init request to dfi_init_done high; range 1..2^CNT_W-1.
- CNT_W, 16, width of the shared down-counter.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, reset; synchronous, active-high.
- start_i, in, 1, single-cycle request to run or re-run the sequence.
- dfi_init_done_i, in, 1, PHY init/training complete.
- dfi_reset_n_o, out, NPHASES, memory reset to each phase; all bits identical.
- dfi_cke_o, out, NPHASES, clock enable to each phase; all bits identical.
- dfi_init_start_o, out, 1, init request to the PHY.
- busy_o, out, 1, sequence in progress.
- ready_o, out, 1, init complete and PHY still reporting done.
- error_o, out, 1, sequence failed.
- err_code_o, out, 2, failure cause: 0 none, 1 no-ack timeout, 2 done timeout, 3 done lost.

Behaviour:
- All outputs are registered. Reset values: dfi_reset_n_o=0, dfi_cke_o=0, dfi_init_start_o=0, busy_o=0, ready_o=0, error_o=0, err_code_o=0. State after reset is IDLE.
- FSM states: IDLE, RST_HOLD, CKE_WAIT, INIT_REQ, INIT_WAIT, READY, ERROR.
- IDLE: reset_n=0, cke=0. start_i=1 moves to RST_HOLD on the next edge and loads the counter with RESET_CYCLES-1.
- RST_HOLD: reset_n=0, cke=0, busy=1.
  - Counter decrements each cycle; at zero, go to CKE_WAIT and load CKE_DELAY_CYCLES-1.
  - reset_n is therefore low for exactly RESET_CYCLES cycles with busy=1.
- CKE_WAIT: reset_n=1, cke=0, busy=1. At zero, go to INIT_REQ and load INIT_TIMEOUT-1.
- INIT_REQ: cke=1, init_start=1, busy=1. Waits for dfi_init_done_i=0 (PHY acknowledged the request).
  - done_i=0 goes to INIT_WAIT; the counter keeps running and is not reloaded.
  - If done_i is already 0 on entry, the transition happens after 1 cycle.
- INIT_WAIT: init_start=1, busy=1.
  - done_i=1 goes to READY; init_start drops on that same edge.
- Timeout: the counter reaching zero in INIT_REQ or INIT_WAIT goes to ERROR.
  - err_code=1 from INIT_REQ, err_code=2 from INIT_WAIT.
  - A done_i transition in the same cycle as the counter reaching zero takes priority over the timeout.
- READY: reset_n=1, cke=1, init_start=0, ready=1.
  - done_i=0 goes to ERROR with err_code=3.
- ERROR: reset_n=0, cke=0, init_start=0, error=1. err_code is held until the next start or reset.
- Restart: start_i in READY or ERROR restarts at RST_HOLD and clears error/err_code on the same edge. start_i is ignored in every other state.
- rst at any time: all outputs and state return to reset values on the next edge, including mid-sequence.
- Counter saturates at 0 and never wraps.

Decomposition:
- Package dfi_init_pkg holds:
  - the FSM state enum;
  - the err_code enum (ERR_NONE, ERR_NO_ACK, ERR_DONE_TO, ERR_DONE_LOST);
  - a helper for counter load values.
- One sub-module, dfi_init_timer: CNT_W-wide loadable down-counter with load, enable and zero_o, saturating at 0. It is shared by all timed states.

Test Plan:
- Nominal sequence (defaults): pulse start_i; PHY drops done 2 cycles after init_start rises and raises it 50 cycles later. Required: reset_n low 16 cycles, then cke low 8 more, then init_start=1 until done rises; ready_o=1 the following cycle; err_code_o=0.
- No acknowledge: done_i stuck at 1. Required: after 1024 cycles in INIT_REQ, error_o=1, err_code_o=1, init_start=0, reset_n and cke all 0.
- Done timeout: done_i drops, then never rises. Required: ERROR with err_code_o=2 exactly 1024 cycles after INIT_REQ entry.
- Done lost: in READY, drop done_i for 1 cycle. Required: error_o=1, err_code_o=3, ready_o=0; a following start_i clears the error and re-runs the full sequence.
- Mid-sequence reset and ignored start: start_i pulses during RST_HOLD are ignored, with no counter reload. Asserting rst at cycle 5 of CKE_WAIT returns all outputs to reset values on the next edge.
- Boundary: RESET_CYCLES=1, CKE_DELAY_CYCLES=1, NPHASES=4. Required: 1-cycle phases, all 4 output bits identical; done rising in the same cycle the timeout expires results in READY, not ERROR.

Source files
------------

// File: rtl/dfi_init_pkg.sv
// Shared types and helpers for the DFI initialization controller.
package dfi_init_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_HOLD,
        ST_CKE_WAIT,
        ST_INIT_REQ,
        ST_INIT_WAIT,
        ST_READY,
        ST_ERROR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_NO_ACK    = 2'd1,
        ERR_DONE_TO   = 2'd2,
        ERR_DONE_LOST = 2'd3
    } err_code_t;

    // A phase of N cycles loads N-1: the zero cycle is the last one of the phase.
    function automatic int unsigned cnt_load(input int unsigned cycles);
        return (cycles == 32'd0) ? 32'd0 : cycles - 32'd1;
    endfunction

endpackage

// File: rtl/dfi_init_if.sv
// DFI init/power-up signals between the controller (master) and the PHY (slave).
interface dfi_init_if #(
    parameter int unsigned NPHASES = 8
) ();

    logic [NPHASES-1:0] dfi_reset_n_o;
    logic [NPHASES-1:0] dfi_cke_o;
    logic               dfi_init_start_o;
    logic               dfi_init_done_i;

    modport master (
        output dfi_reset_n_o,
        output dfi_cke_o,
        output dfi_init_start_o,
        input  dfi_init_done_i
    );

    modport slave (
        input  dfi_reset_n_o,
        input  dfi_cke_o,
        input  dfi_init_start_o,
        output dfi_init_done_i
    );

endinterface

// File: rtl/dfi_init_timer.sv
// Loadable down-counter shared by every timed state; holds at zero instead of wrapping.
module dfi_init_timer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dfi_init_ctrl.sv
// Controller-side DFI init sequencer: reset_n/cke power-up, init request to the PHY,
// completion wait with timeout, and status reporting.
module dfi_init_ctrl
    import dfi_init_pkg::*;
#(
    parameter int unsigned NPHASES          = 8,
    parameter int unsigned RESET_CYCLES     = 16,
    parameter int unsigned CKE_DELAY_CYCLES = 8,
    parameter int unsigned INIT_TIMEOUT     = 1024,
    parameter int unsigned CNT_W            = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    dfi_init_if.master       dfi,
    output logic             busy_o,
    output logic             ready_o,
    output logic             error_o,
    output logic [1:0]       err_code_o
);

    localparam logic [CNT_W-1:0] LD_RST  = CNT_W'(cnt_load(RESET_CYCLES));
    localparam logic [CNT_W-1:0] LD_CKE  = CNT_W'(cnt_load(CKE_DELAY_CYCLES));
    localparam logic [CNT_W-1:0] LD_INIT = CNT_W'(cnt_load(INIT_TIMEOUT));

    state_t           state_q, state_d;
    err_code_t        err_q, err_d;
    logic             tmr_load, tmr_en, tmr_zero;
    logic [CNT_W-1:0] tmr_val;

    logic reset_n_d, cke_d, init_start_d, busy_d, ready_d, error_d;
    logic reset_n_q, cke_q, init_start_q, busy_q, ready_q, error_q;

    dfi_init_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (tmr_val),
        .zero_o   (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        tmr_val  = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d  = ST_RST_HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = LD_RST;
                end
            end
            ST_RST_HOLD: begin
                tmr_en = 1'b1;
                if (tmr_zero) begin
                    state_d  = ST_CKE_WAIT;
                    tmr_load = 1'b1;
                    tmr_val  = LD_CKE;
                end
            end
            ST_CKE_WAIT: begin
                tmr_en = 1'b1;
                if (tmr_zero) begin
                    state_d  = ST_INIT_REQ;
                    tmr_load = 1'b1;
                    tmr_val  = LD_INIT;
                end
            end
            // The timeout spans both init states; a done transition beats an expiring counter.
            ST_INIT_REQ: begin
                tmr_en = 1'b1;
                if (!dfi.dfi_init_done_i) begin
                    state_d = ST_INIT_WAIT;
                end else if (tmr_zero) begin
                    state_d = ST_ERROR;
                    err_d   = ERR_NO_ACK;
                end
            end
            ST_INIT_WAIT: begin
                tmr_en = 1'b1;
                if (dfi.dfi_init_done_i) begin
                    state_d = ST_READY;
                end else if (tmr_zero) begin
                    state_d = ST_ERROR;
                    err_d   = ERR_DONE_TO;
                end
            end
            ST_READY: begin
                if (start_i) begin
                    state_d  = ST_RST_HOLD;
                    err_d    = ERR_NONE;
                    tmr_load = 1'b1;
                    tmr_val  = LD_RST;
                end else if (!dfi.dfi_init_done_i) begin
                    state_d = ST_ERROR;
                    err_d   = ERR_DONE_LOST;
                end
            end
            ST_ERROR: begin
                if (start_i) begin
                    state_d  = ST_RST_HOLD;
                    err_d    = ERR_NONE;
                    tmr_load = 1'b1;
                    tmr_val  = LD_RST;
                end
            end
            default: begin
                state_d = ST_IDLE;
                err_d   = ERR_NONE;
            end
        endcase

        // Outputs are decoded from the next state so the registered copies line up with state_q.
        reset_n_d    = 1'b0;
        cke_d        = 1'b0;
        init_start_d = 1'b0;
        busy_d       = 1'b0;
        ready_d      = 1'b0;
        error_d      = 1'b0;
        unique case (state_d)
            ST_RST_HOLD: busy_d = 1'b1;
            ST_CKE_WAIT: begin
                reset_n_d = 1'b1;
                busy_d    = 1'b1;
            end
            ST_INIT_REQ, ST_INIT_WAIT: begin
                reset_n_d    = 1'b1;
                cke_d        = 1'b1;
                init_start_d = 1'b1;
                busy_d       = 1'b1;
            end
            ST_READY: begin
                reset_n_d = 1'b1;
                cke_d     = 1'b1;
                ready_d   = 1'b1;
            end
            ST_ERROR: error_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            err_q        <= ERR_NONE;
            reset_n_q    <= 1'b0;
            cke_q        <= 1'b0;
            init_start_q <= 1'b0;
            busy_q       <= 1'b0;
            ready_q      <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            err_q        <= err_d;
            reset_n_q    <= reset_n_d;
            cke_q        <= cke_d;
            init_start_q <= init_start_d;
            busy_q       <= busy_d;
            ready_q      <= ready_d;
            error_q      <= error_d;
        end
    end

    assign dfi.dfi_reset_n_o    = {NPHASES{reset_n_q}};
    assign dfi.dfi_cke_o        = {NPHASES{cke_q}};
    assign dfi.dfi_init_start_o = init_start_q;
    assign busy_o               = busy_q;
    assign ready_o              = ready_q;
    assign error_o              = error_q;
    assign err_code_o           = err_q;

endmodule
